lsq_param: RTL and testbench
============================

# lsq_param

Parametrised in-order load/store queue for the Tomasulo core, sitting between the dispatcher/decoder, the common data bus (CDB), the reorder buffer (ROB) and the memory controller. It buffers up to DEPTH memory operations, resolves operands by snooping CDB_PORTS broadcast channels, and issues one access at a time to memory with a valid/ready handshake. It adds three things over the previous generation:
- committed-store survival across rollback with an explicit drain state;
- an IO-region guard so loads with side effects never issue speculatively;
- a sticky commit-order error flag.

## Interface
Parameters:
- DEPTH, 8: queue entries; power of two, at least 2.
- TAG_W, 4: ROB tag width; tag 0 is NULL (operand ready).
- CDB_PORTS, 2: number of snooped broadcast channels.
- IO_BASE, 32'h0003_0000: addresses at or above this value are in the IO region.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- disp_valid_in  in  1  dispatch a new entry.
- disp_ready_out  out  1  equals count_out != DEPTH.
- disp_is_store_in  in  1  1 = store, 0 = load.
- disp_funct_in  in  3  [1:0] size (00 byte, 01 half, 10 word); [2] unsigned load.
- disp_tag_in  in  TAG_W  ROB tag of the entry.
- disp_qj_in / disp_vj_in  in  TAG_W / 32  base register tag / value.
- disp_qk_in / disp_vk_in  in  TAG_W / 32  store data tag / value.
- disp_imm_in  in  32  offset.
- cdb_valid_in  in  CDB_PORTS  one valid bit per channel.
- cdb_tag_in  in  CDB_PORTS*TAG_W  packed tags; channel i occupies bits [i*TAG_W +: TAG_W].
- cdb_data_in  in  CDB_PORTS*32  packed data; channel i occupies bits [i*32 +: 32].
- commit_valid_in / commit_tag_in  in  1 / TAG_W  ROB commit of a store or IO load.
- rollback_in  in  1  mispredict flush.
- mem_req_valid_out  out  1  request valid; held until accepted.
- mem_req_ready_in  in  1  request accepted.
- mem_req_we_out  out  1  1 = write.
- mem_req_addr_out  out  32  access address.
- mem_req_size_out  out  2  access size.
- mem_req_wdata_out  out  32  store data.
- mem_resp_valid_in  in  1  one-cycle pulse: access finished.
- mem_resp_rdata_in  in  32  load data, right-aligned.
- bc_valid_out / bc_tag_out / bc_data_out  out  1 / TAG_W / 32  load result broadcast.
- count_out  out  $clog2(DEPTH)+1  number of occupied entries.
- err_out  out  1  sticky commit-order error.

## Operation
- Queue structure: circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits (including a wrap bit); entries are allocated at tail.
- Entry state: is_store, funct, tag, qj, vj, qk, vk, imm, committed.
- Dispatch: accepted when disp_valid_in && disp_ready_out. Operands whose tag matches a valid CDB channel or bc_tag_out in the same cycle are captured resolved.
- Snoop: every occupied entry compares qj and qk against every valid CDB channel and against its own broadcast. On a match it writes the value and clears the tag to NULL. Channels carry distinct tags, so the lowest-indexed matching channel wins.
- Commit tracking: commit_cnt counts committed-but-unissued entries. A commit marks entry (head + commit_cnt). If that entry's tag is not commit_tag_in, err_out is set and stays set until reset.
- Ready rule, store: committed, qj == NULL and qk == NULL.
- Ready rule, ordinary load: qj == NULL.
- Ready rule, IO load (vj + imm >= IO_BASE, unsigned compare): qj == NULL and committed.
- Address: vj + imm modulo 2^32.
- Load extension: result is sign- or zero-extended from bit 7 or bit 15 according to funct. Word loads and funct[1:0] == 11 pass data through unchanged.
- FSM states: IDLE, REQ, WAIT, DRAIN.
- IDLE → REQ: head occupied and ready. The entry is popped and the request registered.
- REQ → WAIT: on mem_req_ready_in.
- WAIT → IDLE: on mem_resp_valid_in. For a load, a broadcast follows on the next cycle.
- Rollback:
  - tail ← head + commit_cnt; all uncommitted entries are discarded.
  - An in-flight uncommitted load in REQ or WAIT moves to DRAIN. DRAIN completes the memory handshake, suppresses the broadcast, then returns to IDLE.
  - An in-flight store is unaffected.
  - Dispatch and commit in the rollback cycle are ignored.
- Reset values: all outputs 0, FSM in IDLE, head = tail = 0, commit_cnt = 0, err_out = 0.

## Timing
- Dispatch at edge N: the entry is eligible for issue at edge N+1. With resolved operands and memory always ready, mem_req_valid_out rises one cycle after dispatch.
- Request outputs are stable from assertion until the accepting edge.
- bc_valid_out is a one-cycle pulse on the cycle after mem_resp_valid_in; the queue also snoops this broadcast internally.
- Issue throughput: at most one access in flight; a new issue is possible in the cycle after return to IDLE.
- Simultaneous dispatch, commit, snoop and issue in one cycle are all legal. count_out reflects the net change.
- Full: dispatch is ignored when count_out == DEPTH. Pointers wrap modulo DEPTH.

## Configuration
- LSQ_IO_GUARD_EN defined: IO loads wait for commit as described above.
- LSQ_IO_GUARD_EN undefined: every load needs only qj == NULL. IO_BASE is unused, and commits for loads set err_out.

## Test plan
- Store-then-load: store with vj=0x100, imm=4, vk=0xDEADBEEF is committed, then a dependent lb is dispatched. Required: write request to 0x104, then a read request; rdata=0x80 broadcasts 0xFFFFFF80, and lbu broadcasts 0x00000080.
- CDB resolve: dispatch with qj=5 while CDB channel 1 broadcasts tag 5 = 0x200 in the same cycle. Required: request address 0x200 + imm with no extra wait.
- Rollback: 3 entries, the oldest store committed, a load in WAIT, rollback asserted. Required: count_out=1, no broadcast for the load, the store issues afterwards.
- Full/wrap: DEPTH=8, dispatch 8 entries with memory stalled. Required: disp_ready_out=0 and the 9th dispatch dropped; after draining and 8 further dispatches, pointers wrap and data is correct.
- IO guard: load from 0x30000 with vj ready. Required: no request until commit_tag_in matches; the request follows one cycle later.
- Error: commit of a mismatching tag. Required: err_out=1, remaining 1 until rst_n is low.

Source files
------------

// File: rtl/lsq_param.sv
// lsq_param: in-order load/store queue between dispatch, CDB, ROB and memory.
// Buffers up to DEPTH memory ops, resolves operands by snooping CDB_PORTS
// broadcast channels plus its own load broadcast, and issues one access at a
// time over a valid/ready request with a single-cycle response pulse.
// Ports: clk/rst_n; disp_* dispatch (disp_ready_out = count_out != DEPTH);
// cdb_* packed snoop channels; commit_* ROB commit; rollback_in flush;
// mem_req_*/mem_resp_* memory side; bc_* load result broadcast;
// count_out occupancy; err_out sticky commit-order error.
// Optional feature macro: LSQ_IO_GUARD_EN (loads at/above IO_BASE wait for commit).
module lsq_param #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CDB_PORTS = 2,
  parameter logic [31:0] IO_BASE   = 32'h0003_0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        disp_valid_in,
  output logic                        disp_ready_out,
  input  logic                        disp_is_store_in,
  input  logic [2:0]                  disp_funct_in,
  input  logic [TAG_W-1:0]            disp_tag_in,
  input  logic [TAG_W-1:0]            disp_qj_in,
  input  logic [31:0]                 disp_vj_in,
  input  logic [TAG_W-1:0]            disp_qk_in,
  input  logic [31:0]                 disp_vk_in,
  input  logic [31:0]                 disp_imm_in,
  input  logic [CDB_PORTS-1:0]        cdb_valid_in,
  input  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_in,
  input  logic [CDB_PORTS*32-1:0]     cdb_data_in,
  input  logic                        commit_valid_in,
  input  logic [TAG_W-1:0]            commit_tag_in,
  input  logic                        rollback_in,
  output logic                        mem_req_valid_out,
  input  logic                        mem_req_ready_in,
  output logic                        mem_req_we_out,
  output logic [31:0]                 mem_req_addr_out,
  output logic [1:0]                  mem_req_size_out,
  output logic [31:0]                 mem_req_wdata_out,
  input  logic                        mem_resp_valid_in,
  input  logic [31:0]                 mem_resp_rdata_in,
  output logic                        bc_valid_out,
  output logic [TAG_W-1:0]            bc_tag_out,
  output logic [31:0]                 bc_data_out,
  output logic [$clog2(DEPTH):0]      count_out,
  output logic                        err_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

`ifdef LSQ_IO_GUARD_EN
  localparam bit IO_GUARD = 1'b1;
`else
  localparam bit IO_GUARD = 1'b0;
`endif

  typedef struct packed {
    logic             is_store;
    logic [2:0]       funct;
    logic [TAG_W-1:0] tag;
    logic [TAG_W-1:0] qj;
    logic [31:0]      vj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      vk;
    logic [31:0]      imm;
    logic             committed;
  } entry_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  entry_t           ent [DEPTH];
  entry_t           new_ent, hd, cm;
  state_t           state, state_n;
  logic [CNT_W-1:0] head, tail, commit_cnt;
  logic [CNT_W-1:0] head_n, tail_n, commit_cnt_n, occ_cnt, cm_idx;
  logic [31:0]      hd_addr;
  logic             hd_io, hd_ready;
  logic             issue_c, disp_acc_c, cm_c, cm_in_range, cm_mark, cm_err;
  logic             req_valid_n, bc_fire_c, kill_c;
  logic             fl_load, fl_committed;
  logic [TAG_W-1:0] fl_tag;
  logic [2:0]       fl_funct;

  // Operand resolve against CDB and own broadcast; lowest channel wins.
  function automatic logic [TAG_W+31:0] snoop(input logic [TAG_W-1:0] t,
                                              input logic [31:0] v);
    logic [TAG_W+31:0] r;
    r = {t, v};
    if (t != '0) begin
      if (bc_valid_out && bc_tag_out == t) r = {{TAG_W{1'b0}}, bc_data_out};
      for (int i = int'(CDB_PORTS) - 1; i >= 0; i--)
        if (cdb_valid_in[i] && cdb_tag_in[i*TAG_W +: TAG_W] == t)
          r = {{TAG_W{1'b0}}, cdb_data_in[i*32 +: 32]};
    end
    return r;
  endfunction

  // Sign/zero extension of right-aligned load data.
  function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [31:0] d);
    case (f[1:0])
      2'b00:   return f[2] ? {24'h0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
      2'b01:   return f[2] ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign occ_cnt        = tail - head;
  assign disp_ready_out = (count_out != CNT_W'(DEPTH));
  assign hd             = ent[head[PTR_W-1:0]];
  assign hd_addr        = hd.vj + hd.imm;
  assign hd_io          = (hd_addr >= IO_BASE);
  assign cm_idx         = head + commit_cnt;
  assign cm             = ent[cm_idx[PTR_W-1:0]];

  // Head issue eligibility.
  always_comb begin
    hd_ready = 1'b0;
    if (hd.is_store) hd_ready = hd.committed && (hd.qj == '0) && (hd.qk == '0);
    else             hd_ready = (hd.qj == '0) && (!(IO_GUARD && hd_io) || hd.committed);
  end

  assign issue_c     = (state == IDLE) && (occ_cnt != '0) && hd_ready && !rollback_in;
  assign disp_acc_c  = disp_valid_in && disp_ready_out && !rollback_in;
  assign cm_c        = commit_valid_in && !rollback_in;
  assign cm_in_range = (commit_cnt < occ_cnt);
  assign cm_err      = cm_c && (!cm_in_range || (cm.tag != commit_tag_in) ||
                                (!IO_GUARD && !cm.is_store));
  // A commit landing on the head popped this cycle has nothing left to mark.
  assign cm_mark     = cm_c && cm_in_range && !(issue_c && commit_cnt == '0);
  assign kill_c      = rollback_in && fl_load && !fl_committed;

  assign head_n       = head + CNT_W'(issue_c);
  assign tail_n       = rollback_in ? (head + commit_cnt) : (tail + CNT_W'(disp_acc_c));
  assign commit_cnt_n = commit_cnt + CNT_W'(cm_mark) - CNT_W'(issue_c && hd.committed);

  // New entry with same-cycle operand capture.
  always_comb begin
    new_ent           = '0;
    new_ent.is_store  = disp_is_store_in;
    new_ent.funct     = disp_funct_in;
    new_ent.tag       = disp_tag_in;
    new_ent.imm       = disp_imm_in;
    new_ent.committed = 1'b0;
    {new_ent.qj, new_ent.vj} = snoop(disp_qj_in, disp_vj_in);
    {new_ent.qk, new_ent.vk} = snoop(disp_qk_in, disp_vk_in);
  end

  // Entry storage: snoop, commit mark, allocate.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      {ent[i].qj, ent[i].vj} <= snoop(ent[i].qj, ent[i].vj);
      {ent[i].qk, ent[i].vk} <= snoop(ent[i].qk, ent[i].vk);
    end
    if (cm_mark)    ent[cm_idx[PTR_W-1:0]].committed <= 1'b1;
    if (disp_acc_c) ent[tail[PTR_W-1:0]] <= new_ent;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // FSM next state; DRAIN finishes the handshake of a flushed load silently.
  always_comb begin
    state_n     = state;
    req_valid_n = mem_req_valid_out;
    bc_fire_c   = 1'b0;
    case (state)
      IDLE: if (issue_c) begin
        state_n     = REQ;
        req_valid_n = 1'b1;
      end
      REQ: begin
        if (mem_req_ready_in) begin
          state_n     = WAIT;
          req_valid_n = 1'b0;
        end
        if (kill_c) state_n = DRAIN;
      end
      WAIT: begin
        if (mem_resp_valid_in) begin
          state_n   = IDLE;
          bc_fire_c = fl_load && !kill_c;
        end else if (kill_c) begin
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_req_valid_out) begin
          if (mem_req_ready_in) req_valid_n = 1'b0;
        end else if (mem_resp_valid_in) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pointers, request, in-flight and broadcast registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head              <= '0;
      tail              <= '0;
      commit_cnt        <= '0;
      count_out         <= '0;
      err_out           <= 1'b0;
      mem_req_valid_out <= 1'b0;
      mem_req_we_out    <= 1'b0;
      mem_req_addr_out  <= '0;
      mem_req_size_out  <= '0;
      mem_req_wdata_out <= '0;
      fl_load           <= 1'b0;
      fl_committed      <= 1'b0;
      fl_tag            <= '0;
      fl_funct          <= '0;
      bc_valid_out      <= 1'b0;
      bc_tag_out        <= '0;
      bc_data_out       <= '0;
    end else begin
      head              <= head_n;
      tail              <= tail_n;
      commit_cnt        <= commit_cnt_n;
      count_out         <= tail_n - head_n;
      err_out           <= err_out | cm_err;
      mem_req_valid_out <= req_valid_n;
      bc_valid_out      <= bc_fire_c;
      if (issue_c) begin
        mem_req_we_out    <= hd.is_store;
        mem_req_addr_out  <= hd_addr;
        mem_req_size_out  <= hd.funct[1:0];
        mem_req_wdata_out <= hd.vk;
        fl_load           <= !hd.is_store;
        fl_committed      <= hd.committed;
        fl_tag            <= hd.tag;
        fl_funct          <= hd.funct;
      end
      if (bc_fire_c) begin
        bc_tag_out  <= fl_tag;
        bc_data_out <= load_ext(fl_funct, mem_resp_rdata_in);
      end
    end
  end

endmodule

// File: tb/tb_lsq_param.sv
module tb_lsq_param;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned TAG_W     = 4;
  localparam int unsigned CDB_PORTS = 2;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        disp_valid_in, disp_ready_out, disp_is_store_in;
  logic [2:0]                  disp_funct_in;
  logic [TAG_W-1:0]            disp_tag_in, disp_qj_in, disp_qk_in;
  logic [31:0]                 disp_vj_in, disp_vk_in, disp_imm_in;
  logic [CDB_PORTS-1:0]        cdb_valid_in;
  logic [CDB_PORTS*TAG_W-1:0]  cdb_tag_in;
  logic [CDB_PORTS*32-1:0]     cdb_data_in;
  logic                        commit_valid_in, rollback_in;
  logic [TAG_W-1:0]            commit_tag_in;
  logic                        mem_req_valid_out, mem_req_ready_in, mem_req_we_out;
  logic [31:0]                 mem_req_addr_out, mem_req_wdata_out;
  logic [1:0]                  mem_req_size_out;
  logic                        mem_resp_valid_in;
  logic [31:0]                 mem_resp_rdata_in;
  logic                        bc_valid_out;
  logic [TAG_W-1:0]            bc_tag_out;
  logic [31:0]                 bc_data_out;
  logic [$clog2(DEPTH):0]      count_out;
  logic                        err_out;

  int n_checks = 0;
  int n_fail   = 0;

  lsq_param #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CDB_PORTS(CDB_PORTS),
              .IO_BASE(32'h0003_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid_in(disp_valid_in), .disp_ready_out(disp_ready_out),
    .disp_is_store_in(disp_is_store_in), .disp_funct_in(disp_funct_in),
    .disp_tag_in(disp_tag_in), .disp_qj_in(disp_qj_in), .disp_vj_in(disp_vj_in),
    .disp_qk_in(disp_qk_in), .disp_vk_in(disp_vk_in), .disp_imm_in(disp_imm_in),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .commit_valid_in(commit_valid_in), .commit_tag_in(commit_tag_in),
    .rollback_in(rollback_in),
    .mem_req_valid_out(mem_req_valid_out), .mem_req_ready_in(mem_req_ready_in),
    .mem_req_we_out(mem_req_we_out), .mem_req_addr_out(mem_req_addr_out),
    .mem_req_size_out(mem_req_size_out), .mem_req_wdata_out(mem_req_wdata_out),
    .mem_resp_valid_in(mem_resp_valid_in), .mem_resp_rdata_in(mem_resp_rdata_in),
    .bc_valid_out(bc_valid_out), .bc_tag_out(bc_tag_out), .bc_data_out(bc_data_out),
    .count_out(count_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dispatch(input logic st, input logic [2:0] f, input logic [3:0] tag,
                          input logic [3:0] qj, input logic [31:0] vj,
                          input logic [3:0] qk, input logic [31:0] vk,
                          input logic [31:0] imm);
    disp_valid_in = 1'b1; disp_is_store_in = st; disp_funct_in = f; disp_tag_in = tag;
    disp_qj_in = qj; disp_vj_in = vj; disp_qk_in = qk; disp_vk_in = vk; disp_imm_in = imm;
    tick();
    disp_valid_in = 1'b0;
    cdb_valid_in  = '0;
  endtask

  task automatic commit(input logic [3:0] tag);
    commit_valid_in = 1'b1; commit_tag_in = tag;
    tick();
    commit_valid_in = 1'b0;
  endtask

  // Wait (bounded) for a request, check it, accept it for one cycle.
  task automatic wait_req(input string name, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < 20 && !mem_req_valid_out; i++) tick();
    check({name, "_valid"}, 32'(mem_req_valid_out), 32'd1);
    check({name, "_we"},    32'(mem_req_we_out), 32'(we));
    check({name, "_addr"},  mem_req_addr_out, addr);
    check({name, "_size"},  32'(mem_req_size_out), 32'(size));
    if (we) check({name, "_wdata"}, mem_req_wdata_out, wdata);
    mem_req_ready_in = 1'b1;
    tick();
    mem_req_ready_in = 1'b0;
  endtask

  task automatic serve(input logic [31:0] rdata);
    mem_resp_valid_in = 1'b1; mem_resp_rdata_in = rdata;
    tick();
    mem_resp_valid_in = 1'b0;
  endtask

  task automatic check_bc(input string name, input logic [3:0] tag, input logic [31:0] data);
    check({name, "_bc_valid"}, 32'(bc_valid_out), 32'd1);
    check({name, "_bc_tag"},   32'(bc_tag_out), 32'(tag));
    check({name, "_bc_data"},  bc_data_out, data);
    tick();
    check({name, "_bc_pulse"}, 32'(bc_valid_out), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_err", 32'(err_out), 32'd0);
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid_out), 32'd0);
    check("rst_bc_valid", 32'(bc_valid_out), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Fill to DEPTH with stalled memory, drop one extra, then commit and drain.
  task automatic fill_drain(input logic [31:0] base);
    for (int i = 0; i < int'(DEPTH); i++)
      dispatch(1'b1, 3'b010, 4'(i + 1), 4'd0, 32'h1000 + 32'(i * 4), 4'd0, base + 32'(i), 32'd0);
    check("full_count", 32'(count_out), 32'd8);
    check("full_ready", 32'(disp_ready_out), 32'd0);
    dispatch(1'b1, 3'b010, 4'd9, 4'd0, 32'h2000, 4'd0, 32'h9999, 32'd0);
    check("full_drop_count", 32'(count_out), 32'd8);
    for (int i = 0; i < int'(DEPTH); i++) commit(4'(i + 1));
    for (int i = 0; i < int'(DEPTH); i++) begin
      wait_req("full_st", 1'b1, 32'h1000 + 32'(i * 4), 2'b10, base + 32'(i));
      serve(32'd0);
    end
    tick();
    check("drain_count", 32'(count_out), 32'd0);
    check("drain_ready", 32'(disp_ready_out), 32'd1);
  endtask

  logic [2:0]  ld_f   [5];
  logic [31:0] ld_rd  [5];
  logic [31:0] ld_exp [5];

  initial begin
    ld_f   = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    ld_rd  = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'h1234_8001, 32'hCAFE_F00D};
    ld_exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hCAFE_F00D};

    disp_valid_in = 0; disp_is_store_in = 0; disp_funct_in = '0; disp_tag_in = '0;
    disp_qj_in = '0; disp_vj_in = '0; disp_qk_in = '0; disp_vk_in = '0; disp_imm_in = '0;
    cdb_valid_in = '0; cdb_tag_in = '0; cdb_data_in = '0;
    commit_valid_in = 0; commit_tag_in = '0; rollback_in = 0;
    mem_req_ready_in = 0; mem_resp_valid_in = 0; mem_resp_rdata_in = '0;
    do_reset();

    // Store waits for commit, then loads with each extension mode.
    dispatch(1'b1, 3'b010, 4'd1, 4'd0, 32'h100, 4'd0, 32'hDEAD_BEEF, 32'd4);
    tick();
    check("st_hold", 32'(mem_req_valid_out), 32'd0);
    commit(4'd1);
    wait_req("st", 1'b1, 32'h104, 2'b10, 32'hDEAD_BEEF);
    serve(32'd0);
    check("st_no_bc", 32'(bc_valid_out), 32'd0);
    for (int i = 0; i < 5; i++) begin
      dispatch(1'b0, ld_f[i], 4'(2 + i), 4'd0, 32'h100, 4'd0, 32'd0, 32'd4);
      wait_req("ld", 1'b0, 32'h104, ld_f[i][1:0], 32'd0);
      serve(ld_rd[i]);
      check_bc("ld", 4'(2 + i), ld_exp[i]);
    end

    // Same-cycle CDB capture on channel 1; channel 0 carries another tag.
    cdb_valid_in = 2'b11;
    cdb_tag_in   = {4'd5, 4'd6};
    cdb_data_in  = {32'h0000_0200, 32'h0000_0999};
    dispatch(1'b0, 3'b010, 4'd4, 4'd5, 32'd0, 4'd0, 32'd0, 32'h10);
    check("cdb_lat0", 32'(mem_req_valid_out), 32'd0);
    tick();
    check("cdb_lat1", 32'(mem_req_valid_out), 32'd1);
    wait_req("cdb", 1'b0, 32'h210, 2'b10, 32'd0);
    serve(32'h55);
    check_bc("cdb", 4'd4, 32'h55);

    // Rollback with load in WAIT, committed store and a younger load queued.
    dispatch(1'b0, 3'b010, 4'd6, 4'd0, 32'h40, 4'd0, 32'd0, 32'd0);
    dispatch(1'b1, 3'b010, 4'd7, 4'd0, 32'h50, 4'd0, 32'h1234, 32'd0);
    dispatch(1'b0, 3'b010, 4'd8, 4'd0, 32'h60, 4'd0, 32'd0, 32'd0);
    wait_req("rb_ld", 1'b0, 32'h40, 2'b10, 32'd0);
    commit(4'd7);
    check("rb_pre_count", 32'(count_out), 32'd2);
    rollback_in = 1'b1;
    tick();
    rollback_in = 1'b0;
    check("rb_count", 32'(count_out), 32'd1);
    serve(32'hABCD);
    check("rb_no_bc", 32'(bc_valid_out), 32'd0);
    wait_req("rb_st", 1'b1, 32'h50, 2'b10, 32'h1234);
    serve(32'd0);
    tick();
    check("rb_post_count", 32'(count_out), 32'd0);

    // Full and wrap, twice around the ring.
    fill_drain(32'hA000_0000);
    fill_drain(32'hB000_0000);
    check("full_err", 32'(err_out), 32'd0);

    // IO-region load.
    dispatch(1'b0, 3'b010, 4'd3, 4'd0, 32'h0003_0000, 4'd0, 32'd0, 32'd0);
`ifdef LSQ_IO_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      check("io_hold", 32'(mem_req_valid_out), 32'd0);
      tick();
    end
    commit(4'd3);
    check("io_commit_edge", 32'(mem_req_valid_out), 32'd0);
    tick();
    check("io_req_after_commit", 32'(mem_req_valid_out), 32'd1);
`else
    tick();
    check("io_req_no_guard", 32'(mem_req_valid_out), 32'd1);
`endif
    wait_req("io", 1'b0, 32'h0003_0000, 2'b10, 32'd0);
    serve(32'h1234_5678);
    check_bc("io", 4'd3, 32'h1234_5678);
    check("io_err", 32'(err_out), 32'd0);

`ifndef LSQ_IO_GUARD_EN
    // Without the guard, committing a load is an ordering error.
    dispatch(1'b0, 3'b010, 4'd10, 4'd9, 32'd0, 4'd0, 32'd0, 32'd0);
    commit(4'd10);
    check("ld_commit_err", 32'(err_out), 32'd1);
    do_reset();
`endif

    // Mismatching commit tag: sticky until reset.
    dispatch(1'b1, 3'b010, 4'd4, 4'd0, 32'h80, 4'd0, 32'd1, 32'd0);
    check("err_before", 32'(err_out), 32'd0);
    commit(4'd5);
    check("err_set", 32'(err_out), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("err_sticky", 32'(err_out), 32'd1);
    do_reset();
    check("err_cleared", 32'(err_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
